i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_fifo.sv | 56 +++++
 rtl/i2s_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-chain definitions: sample width, I2S frame geometry and the
// serialiser state encoding.
package audio_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_SLOTS = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Mono source is sent as identical left and right words.
    function automatic logic [2*SAMPLE_W-1:0] mono_frame(input sample_t s);
        return {s, s};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with explicit occupancy count; a pop frees a
// slot for a push in the same cycle, and a pop while empty is ignored.
module sample_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [SAMPLE_W-1:0]         push_data,
    input  logic                        pop,
    output logic [SAMPLE_W-1:0]         pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; power-of-two depth makes the wrap free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: buffers strobed samples and serialises each one as a
// duplicated left/right frame of 32 BCLK slots with the I2S one-bit delay.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_in,
    input  logic                datain_valid,
    input  logic                enable,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                fifo_full,
    output logic                overflow,
    output logic                underrun
);

    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SR_W  = 2 * SAMPLE_W;

    logic [0:0]       state;
    logic [CW-1:0]    div_cnt;
    logic [4:0]       slot;
    logic [SR_W-1:0]  shreg;
    sample_t          next_word;
    sample_t          fifo_data;
    logic             fifo_at_cap;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             tick;
    logic             frame_end;
    logic             pop;

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SAMPLE_W   (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (datain_valid),
        .push_data (audio_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_at_cap),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign tick      = (state == ST_RUN) && (div_cnt == CW'(CLK_DIV - 1));
    assign frame_end = tick && i2s_bclk && (slot == 5'(FRAME_SLOTS - 1));
    // Slot 0 starts either on leaving IDLE or when a frame rolls into the next.
    assign pop       = enable && (((state == ST_IDLE)) || frame_end);

    // Divider, slot counter, state machine, shift register and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            slot      <= 5'd0;
            shreg     <= '0;
            next_word <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overflow <= datain_valid && fifo_at_cap && !pop;
            underrun <= pop && fifo_empty;
            if (pop) begin
                next_word <= fifo_empty ? '0 : fifo_data;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_RUN;
                        div_cnt   <= '0;
                        slot      <= 5'd0;
                        i2s_bclk  <= 1'b0;
                        i2s_lrck  <= 1'b0;
                        i2s_sdata <= shreg[SR_W-2];
                        shreg     <= shreg << 1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        i2s_bclk <= !i2s_bclk;
                        if (i2s_bclk) begin
                            if (frame_end) begin
                                slot     <= 5'd0;
                                i2s_lrck <= 1'b0;
                                if (enable) begin
                                    // Slot 0 carries the right word's LSB left in the register.
                                    i2s_sdata <= shreg[SR_W-2];
                                    shreg     <= shreg << 1;
                                end else begin
                                    state     <= ST_IDLE;
                                    i2s_sdata <= 1'b0;
                                end
                            end else begin
                                slot     <= slot + 5'd1;
                                i2s_lrck <= (slot >= 5'd15);
                                if (slot == 5'd0) begin
                                    shreg     <= mono_frame(next_word);
                                    i2s_sdata <= next_word[SAMPLE_W-1];
                                end else begin
                                    i2s_sdata <= shreg[SR_W-2];
                                    shreg     <= shreg << 1;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
